// File: rtl/div_scheduler_pkg.sv
// rtl/div_scheduler_pkg.sv - FSM encodings, response flag type and pointer helper
package div_scheduler_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef struct packed {
        logic divzero;
        logic timeout;
    } rsp_flags_t;

    localparam rsp_flags_t FLAGS_NONE    = '{divzero: 1'b0, timeout: 1'b0};
    localparam rsp_flags_t FLAGS_DIVZERO = '{divzero: 1'b1, timeout: 1'b0};
    localparam rsp_flags_t FLAGS_TIMEOUT = '{divzero: 1'b0, timeout: 1'b1};

    function automatic int next_ptr(input int g, input int n);
        return (g + 1) % n;
    endfunction

endpackage

// File: rtl/div_scheduler_if.sv
// rtl/div_scheduler_if.sv - requester and divider signal bundle for the scheduler
interface div_scheduler_if #(
    parameter int WIDTH = 12,
    parameter int NREQ  = 3
) ();
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_dividend;
    logic [NREQ*WIDTH-1:0] req_divisor;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_quotient;
    logic                  rsp_divzero;
    logic                  rsp_timeout;
    logic [WIDTH-1:0]      div_dividend;
    logic [WIDTH-1:0]      div_divisor;
    logic                  div_start;
    logic                  div_busy;
    logic [WIDTH-1:0]      div_res;
    logic                  div_ready;

    modport slave (
        input  req_valid, req_dividend, req_divisor, div_busy, div_res, div_ready,
        output req_ready, rsp_valid, rsp_quotient, rsp_divzero, rsp_timeout,
               div_dividend, div_divisor, div_start
    );

    modport master (
        output req_valid, req_dividend, req_divisor, div_busy, div_res, div_ready,
        input  req_ready, rsp_valid, rsp_quotient, rsp_divzero, rsp_timeout,
               div_dividend, div_divisor, div_start
    );
endinterface

// File: rtl/div_scheduler_rr_arbiter.sv
// rtl/div_scheduler_rr_arbiter.sv - combinational round-robin pick, first request at or after ptr
module div_scheduler_rr_arbiter #(
    parameter int NREQ = 3,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);
    int j;

    // Walk offsets from farthest to nearest so the nearest request wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = IW'(j);
                any      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/div_scheduler.sv
// rtl/div_scheduler.sv - round-robin sharing of one sequential divider with
// local divide-by-zero handling and a hung-divider timeout
module div_scheduler
    import div_scheduler_pkg::*;
#(
    parameter int WIDTH   = 12,
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    div_scheduler_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    logic [1:0]       state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    gidx;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] quo;
    rsp_flags_t       flags;
    logic [CW-1:0]    cnt;

    logic [NREQ-1:0]  arb_grant;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             unused_busy;

    div_scheduler_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign sel_a       = bus.req_dividend[int'(arb_idx)*WIDTH +: WIDTH];
    assign sel_b       = bus.req_divisor[int'(arb_idx)*WIDTH +: WIDTH];
    assign unused_busy = bus.div_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ptr   <= '0;
            gidx  <= '0;
            op_a  <= '0;
            op_b  <= '0;
            quo   <= '0;
            flags <= FLAGS_NONE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        gidx <= arb_idx;
                        op_a <= sel_a;
                        op_b <= sel_b;
                        ptr  <= IW'(next_ptr(int'(arb_idx), NREQ));
                        if (sel_b == '0) begin
                            quo   <= '1;
                            flags <= FLAGS_DIVZERO;
                            state <= ST_RESP;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.div_ready) begin
                        quo   <= bus.div_res;
                        flags <= FLAGS_NONE;
                        state <= ST_RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        quo   <= '1;
                        flags <= FLAGS_TIMEOUT;
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Grant is combinational in IDLE; gating with rst_n keeps it quiet while reset is held.
    assign bus.req_ready    = (state == ST_IDLE && rst_n) ? arb_grant : '0;
    assign bus.rsp_valid    = (state == ST_RESP) ? (NREQ'(1) << gidx) : '0;
    assign bus.rsp_quotient = (state == ST_RESP) ? quo : '0;
    assign bus.rsp_divzero  = (state == ST_RESP) && flags.divzero;
    assign bus.rsp_timeout  = (state == ST_RESP) && flags.timeout;
    assign bus.div_start    = (state == ST_ISSUE);
    assign bus.div_dividend = op_a;
    assign bus.div_divisor  = op_b;
endmodule
